// File: rtl/timing_mon_pkg.sv
// Shared types and constants for the video timing lock monitor.
// The tolerant field comparison is built when TIMING_TOL_EN is defined.
package timing_mon_pkg;

  localparam int unsigned FIELD_W    = 13;
  localparam int unsigned TOTAL_W    = 15;
  localparam int unsigned NUM_FIELDS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  localparam int unsigned FLD_H_SYNC = 0;
  localparam int unsigned FLD_H_BP   = 1;
  localparam int unsigned FLD_H_ACT  = 2;
  localparam int unsigned FLD_H_FP   = 3;
  localparam int unsigned FLD_V_SYNC = 4;
  localparam int unsigned FLD_V_BP   = 5;
  localparam int unsigned FLD_V_ACT  = 6;
  localparam int unsigned FLD_V_FP   = 7;

  typedef logic [NUM_FIELDS-1:0][FIELD_W-1:0] field_vec_t;

  // Sizes published to the scaler when lock is declared.
  typedef struct packed {
    logic [FIELD_W-1:0] h_active;
    logic [FIELD_W-1:0] v_active;
    logic [TOTAL_W-1:0] h_total;
    logic [TOTAL_W-1:0] v_total;
  } lock_info_t;

  // Four 13-bit fields cannot overflow a 15-bit sum.
  function automatic logic [TOTAL_W-1:0] sum4(input logic [FIELD_W-1:0] a,
                                               input logic [FIELD_W-1:0] b,
                                               input logic [FIELD_W-1:0] c,
                                               input logic [FIELD_W-1:0] d);
    return TOTAL_W'(a) + TOTAL_W'(b) + TOTAL_W'(c) + TOTAL_W'(d);
  endfunction

endpackage

// File: rtl/timing_field_cmp.sv
// Compares one measured timing field against its reference snapshot.
// With TIMING_TOL_EN defined a difference of one count still matches.
module timing_field_cmp
  import timing_mon_pkg::*;
(
  input  logic [FIELD_W-1:0] sample,
  input  logic [FIELD_W-1:0] ref_val,
  output logic               match_c
);

`ifdef TIMING_TOL_EN
  localparam int unsigned EXT_W = FIELD_W + 1;

  logic [EXT_W-1:0] s_ext;
  logic [EXT_W-1:0] r_ext;

  // Extra bit keeps the +1 from wrapping at the field maximum.
  assign s_ext   = EXT_W'(sample);
  assign r_ext   = EXT_W'(ref_val);
  assign match_c = (s_ext == r_ext) ||
                   (s_ext == r_ext + EXT_W'(1)) ||
                   (r_ext == s_ext + EXT_W'(1));
`else
  assign match_c = (sample == ref_val);
`endif

endmodule

// File: rtl/timing_lock_monitor.sv
// Samples detector timing once per frame, declares lock after LOCK_FRAMES identical
// frames, and runs a VS watchdog. Optional build macro: TIMING_TOL_EN (+/-1 match).
module timing_lock_monitor
  import timing_mon_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES    = 3,
  parameter int unsigned SAMPLE_DLY     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vs,
  input  logic [12:0]   i_h_sync,
  input  logic [12:0]   i_h_back_porch,
  input  logic [12:0]   i_h_active,
  input  logic [12:0]   i_h_front_porch,
  input  logic [12:0]   i_v_sync,
  input  logic [12:0]   i_v_back_porch,
  input  logic [12:0]   i_v_active,
  input  logic [12:0]   i_v_front_porch,
  output logic          o_locked,
  output logic          o_fmt_change,
  output logic          o_no_signal,
  output logic [12:0]   o_h_active,
  output logic [12:0]   o_v_active,
  output logic [14:0]   o_h_total,
  output logic [14:0]   o_v_total,
  output logic [1:0]    o_state
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DLY_W = 4;
  localparam int unsigned WD_W  = 24;

  mon_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             vs_q;
  logic [DLY_W-1:0] dly_q;
  logic [WD_W-1:0]  wd_q;
  field_vec_t       ref_q;
  logic             ref_valid_q;
  lock_info_t       lock_q;

  field_vec_t            sample_c;
  logic [NUM_FIELDS-1:0] fld_match_c;
  logic                  pos_vs_c;
  logic                  strobe_c;
  logic                  wd_fire_c;
  logic                  valid_c;
  logic                  match_c;
  logic                  lock_now_c;
  lock_info_t            lock_c;

  assign sample_c = {i_v_front_porch, i_v_active, i_v_back_porch, i_v_sync,
                     i_h_front_porch, i_h_active, i_h_back_porch, i_h_sync};

  assign pos_vs_c  = i_vs & ~vs_q;
  // Delay counter reads 1 exactly SAMPLE_DLY cycles after the edge that loaded it.
  assign strobe_c  = (dly_q == DLY_W'(1));
  assign wd_fire_c = ~pos_vs_c && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  for (genvar g = 0; g < NUM_FIELDS; g++) begin : g_cmp
    timing_field_cmp u_cmp (
      .sample  (sample_c[g]),
      .ref_val (ref_q[g]),
      .match_c (fld_match_c[g])
    );
  end

  // A zero in any field means the detector has not measured this frame.
  always_comb begin
    valid_c = 1'b1;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (sample_c[i] == '0) valid_c = 1'b0;
    end
  end

  assign match_c    = ref_valid_q & (&fld_match_c);
  assign lock_now_c = ((cnt_q + CNT_W'(1)) == CNT_W'(LOCK_FRAMES));

  assign lock_c.h_active = sample_c[FLD_H_ACT];
  assign lock_c.v_active = sample_c[FLD_V_ACT];
  assign lock_c.h_total  = sum4(sample_c[FLD_H_SYNC], sample_c[FLD_H_BP],
                                sample_c[FLD_H_ACT], sample_c[FLD_H_FP]);
  assign lock_c.v_total  = sum4(sample_c[FLD_V_SYNC], sample_c[FLD_V_BP],
                                sample_c[FLD_V_ACT], sample_c[FLD_V_FP]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      vs_q         <= 1'b0;
      dly_q        <= '0;
      wd_q         <= '0;
      ref_q        <= '0;
      ref_valid_q  <= 1'b0;
      lock_q       <= '0;
      o_locked     <= 1'b0;
      o_fmt_change <= 1'b0;
      o_no_signal  <= 1'b0;
    end else begin
      vs_q         <= i_vs;
      o_fmt_change <= 1'b0;

      if (pos_vs_c) begin
        dly_q <= DLY_W'(SAMPLE_DLY);
      end else if (dly_q != '0) begin
        dly_q <= dly_q - DLY_W'(1);
      end

      // Watchdog saturates so it fires once per loss of VS.
      if (pos_vs_c) begin
        wd_q        <= '0;
        o_no_signal <= 1'b0;
      end else if (wd_q != WD_W'(TIMEOUT_CYCLES)) begin
        wd_q <= wd_q + WD_W'(1);
      end

      if (wd_fire_c) begin
        o_no_signal <= 1'b1;
        o_locked    <= 1'b0;
        state_q     <= IDLE;
        cnt_q       <= '0;
        ref_valid_q <= 1'b0;
        if (state_q == LOCKED) o_fmt_change <= 1'b1;
      end else if (strobe_c) begin
        case (state_q)
          IDLE: begin
            if (valid_c) begin
              state_q     <= ACQ;
              cnt_q       <= CNT_W'(1);
              ref_q       <= sample_c;
              ref_valid_q <= 1'b1;
            end
          end
          ACQ: begin
            if (!valid_c) begin
              state_q     <= IDLE;
              cnt_q       <= '0;
              ref_valid_q <= 1'b0;
            end else if (match_c) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (lock_now_c) begin
                state_q  <= LOCKED;
                o_locked <= 1'b1;
                lock_q   <= lock_c;
              end
            end else begin
              cnt_q <= CNT_W'(1);
              ref_q <= sample_c;
            end
          end
          LOCKED: begin
            if (!valid_c) begin
              state_q      <= IDLE;
              cnt_q        <= '0;
              ref_valid_q  <= 1'b0;
              o_locked     <= 1'b0;
              o_fmt_change <= 1'b1;
            end else if (!match_c) begin
              state_q      <= ACQ;
              cnt_q        <= CNT_W'(1);
              ref_q        <= sample_c;
              o_locked     <= 1'b0;
              o_fmt_change <= 1'b1;
            end
          end
          default: begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ref_valid_q <= 1'b0;
            o_locked    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_h_active = lock_q.h_active;
  assign o_v_active = lock_q.v_active;
  assign o_h_total  = lock_q.h_total;
  assign o_v_total  = lock_q.v_total;
  assign o_state    = state_q;

endmodule

// File: tb/tb_timing_lock_monitor.sv
// Randomized bench for timing_lock_monitor against an edge-indexed reference model.
module tb_timing_lock_monitor;

  localparam int unsigned L = 3;
  localparam int unsigned D = 4;
  localparam int unsigned T = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs  = 1'b0;
  logic [12:0] fld [8];

  logic        o_locked, o_fmt_change, o_no_signal;
  logic [12:0] o_h_active, o_v_active;
  logic [14:0] o_h_total, o_v_total;
  logic [1:0]  o_state;

  always #5 clk = ~clk;

  timing_lock_monitor #(
    .LOCK_FRAMES    (L),
    .SAMPLE_DLY     (D),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_vs            (vs),
    .i_h_sync        (fld[0]),
    .i_h_back_porch  (fld[1]),
    .i_h_active      (fld[2]),
    .i_h_front_porch (fld[3]),
    .i_v_sync        (fld[4]),
    .i_v_back_porch  (fld[5]),
    .i_v_active      (fld[6]),
    .i_v_front_porch (fld[7]),
    .o_locked        (o_locked),
    .o_fmt_change    (o_fmt_change),
    .o_no_signal     (o_no_signal),
    .o_h_active      (o_h_active),
    .o_v_active      (o_v_active),
    .o_h_total       (o_h_total),
    .o_v_total       (o_v_total),
    .o_state         (o_state)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: everything indexed by clock edge number.
  longint n = 0;
  bit     prev_vs;
  longint strobe_edge, last_clear;
  int     m_state, m_cnt;
  bit     m_refv;
  int     m_ref [8];
  bit     e_fmt, e_nos;
  int     e_hact, e_vact, e_htot, e_vtot;

  function automatic bit fmatch(input int s, input int r);
`ifdef TIMING_TOL_EN
    return (s - r <= 1) && (r - s <= 1);
`else
    return s == r;
`endif
  endfunction

  task automatic model_edge();
    bit pos, is_strobe, fire, valid, match;
    n++;
    if (rst) begin
      prev_vs = 0; strobe_edge = -1; last_clear = n;
      m_state = 0; m_cnt = 0; m_refv = 0;
      e_fmt = 0; e_nos = 0; e_hact = 0; e_vact = 0; e_htot = 0; e_vtot = 0;
      return;
    end
    pos       = vs && !prev_vs;
    prev_vs   = vs;
    is_strobe = (n == strobe_edge);
    fire      = !pos && (n == last_clear + T);
    if (pos) begin
      strobe_edge = n + D;
      last_clear  = n;
      e_nos       = 0;
    end
    e_fmt = 0;
    valid = 1; match = m_refv;
    for (int i = 0; i < 8; i++) begin
      if (fld[i] == 0) valid = 0;
      if (!fmatch(int'(fld[i]), m_ref[i])) match = 0;
    end
    if (fire) begin
      e_nos = 1;
      if (m_state == 2) e_fmt = 1;
      m_state = 0; m_cnt = 0; m_refv = 0;
    end else if (is_strobe) begin
      if (!valid) begin
        if (m_state == 2) e_fmt = 1;
        m_state = 0; m_cnt = 0; m_refv = 0;
      end else if (m_state == 0 || !match) begin
        if (m_state == 2) e_fmt = 1;
        m_state = 1; m_cnt = 1; m_refv = 1;
        for (int i = 0; i < 8; i++) m_ref[i] = int'(fld[i]);
      end else if (m_state == 1) begin
        m_cnt++;
        if (m_cnt == L) begin
          m_state = 2;
          e_hact = fld[2]; e_vact = fld[6];
          e_htot = fld[0] + fld[1] + fld[2] + fld[3];
          e_vtot = fld[4] + fld[5] + fld[6] + fld[7];
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("ctl", {59'd0, o_locked, o_fmt_change, o_no_signal, o_state},
               {59'd0, (m_state == 2), e_fmt, e_nos, 2'(m_state)});
    chk("dat", {8'd0, o_h_active, o_v_active, o_h_total, o_v_total},
               {8'd0, 13'(e_hact), 13'(e_vact), 15'(e_htot), 15'(e_vtot)});
  endtask

  task automatic frame(input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      vs = (i < hi);
      tick();
    end
  endtask

  task automatic set_f(input int a, input int b, input int c, input int d,
                       input int e, input int f, input int g, input int h);
    fld[0] = 13'(a); fld[1] = 13'(b); fld[2] = 13'(c); fld[3] = 13'(d);
    fld[4] = 13'(e); fld[5] = 13'(f); fld[6] = 13'(g); fld[7] = 13'(h);
  endtask

  task automatic do_reset();
    rst = 1; vs = 0;
    repeat (2) tick();
    rst = 0;
  endtask

  initial begin
    set_f(44, 148, 1920, 88, 5, 36, 1080, 4);
    do_reset();
    chk("reset_state", {62'd0, o_state}, 64'd0);

    // Standard 1080p: lock after the third strobe.
    repeat (6) frame(40, 3);
    chk("lock_1080", {63'd0, o_locked}, 64'd1);
    chk("htot_1080", {49'd0, o_h_total}, 64'd2200);
    chk("vtot_1080", {49'd0, o_v_total}, 64'd1125);
    chk("hact_1080", {51'd0, o_h_active}, 64'd1920);
    chk("vact_1080", {51'd0, o_v_active}, 64'd1080);

    // Format change to 1280 active and relock.
    fld[2] = 13'd1280;
    frame(40, 3);
    chk("chg_state", {62'd0, o_state}, 64'd1);
    repeat (3) frame(40, 3);
    chk("htot_1280", {49'd0, o_h_total}, 64'd1560);

    // VS lost while locked, then restored.
    vs = 0;
    repeat (1100) tick();
    chk("nosig_set", {63'd0, o_no_signal}, 64'd1);
    repeat (4) frame(40, 3);
    chk("nosig_clr", {63'd0, o_no_signal}, 64'd0);
    chk("relock", {63'd0, o_locked}, 64'd1);

    // Invalid frame during acquisition.
    do_reset();
    frame(40, 3);
    fld[6] = 13'd0;
    frame(40, 3);
    chk("inv_idle", {62'd0, o_state}, 64'd0);
    fld[6] = 13'd1080;
    repeat (4) frame(40, 3);

    // Retriggered VS edge, then reset mid-acquisition.
    vs = 1; tick(); vs = 0; tick();
    frame(40, 2);
    do_reset();
    frame(40, 2);
    frame(3, 1);
    rst = 1; tick(); rst = 0;
    chk("rst_mid", {59'd0, o_locked, o_fmt_change, o_no_signal, o_state}, 64'd0);

    // Front porch jitter of one count.
    for (int k = 0; k < 8; k++) begin
      fld[3] = 13'((k % 2 == 0) ? 88 : 89);
      frame(40, 3);
    end
`ifdef TIMING_TOL_EN
    chk("jitter_lock", {63'd0, o_locked}, 64'd1);
`else
    chk("jitter_lock", {63'd0, o_locked}, 64'd0);
`endif

    // Maximum field values give the largest totals.
    set_f(8191, 8191, 8191, 8191, 8191, 8191, 8191, 8191);
    repeat (4) frame(30, 2);
    chk("htot_max", {49'd0, o_h_total}, 64'd32764);

    // Random frames: mostly repeats, some jitter, zeros, new formats and short periods.
    for (int k = 0; k < 80; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 10) fld[$urandom_range(0, 7)] = 13'd0;
      else if (r < 20) fld[$urandom_range(0, 7)] = 13'($urandom_range(1, 8191));
      else if (r < 30) begin
        for (int i = 0; i < 8; i++) fld[i] = 13'($urandom_range(1, 8191));
      end else if (r < 40) begin
        for (int i = 0; i < 8; i++) if (fld[i] == 0) fld[i] = 13'd1;
        fld[3] = (fld[3] == 13'd8191) ? 13'd8190 : fld[3] + 13'd1;
      end else begin
        for (int i = 0; i < 8; i++) if (fld[i] == 0) fld[i] = 13'd7;
      end
      frame(int'(($urandom_range(0, 9) == 0) ? $urandom_range(2, 5) : $urandom_range(8, 60)),
            int'($urandom_range(1, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timing_lock_monitor.md
Name: timing_lock_monitor

Overview:
Downstream consumer of the video timing detector. Samples the eight measured h/v timing fields once per frame and declares lock after a run of identical frames. Publishes latched active/total sizes for the scaler setup logic, flags format changes, and flags loss of signal via a VS watchdog.

Parameters:
LOCK_FRAMES, 3, consecutive identical valid samples required for lock (legal range 2..15)
SAMPLE_DLY, 4, cycles from VS rising edge to sample strobe; lets detector outputs settle (legal range 1..15)
TIMEOUT_CYCLES, 12000000, cycles without a VS rising edge before no-signal; must exceed SAMPLE_DLY and be below 2^24

Ports:
clk  in  1  single clock, same domain as detector
rst  in  1  synchronous, active-high reset
i_vs  in  1  raw vsync, same signal the detector sees
i_h_sync / i_h_back_porch / i_h_active / i_h_front_porch  in  13 each  measured horizontal fields
i_v_sync / i_v_back_porch / i_v_active / i_v_front_porch  in  13 each  measured vertical fields
o_locked  out  1  level; timing stable
o_fmt_change  out  1  one-cycle pulse on any exit from LOCKED
o_no_signal  out  1  level; VS watchdog expired
o_h_active  out  13  latched at lock
o_v_active  out  13  latched at lock
o_h_total  out  15  latched sum of the four h fields
o_v_total  out  15  latched sum of the four v fields
o_state  out  2  0=IDLE 1=ACQ 2=LOCKED (debug)

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: all outputs 0, state IDLE, match count 0, reference snapshot invalid, delay and watchdog counters 0.
- VS edge: i_vs registered once; pos_vs = i_vs & ~vs_q.
- Sample timing:
  - pos_vs loads the delay counter. The sample strobe fires SAMPLE_DLY cycles after pos_vs, for one cycle.
  - A pos_vs arriving during the delay restarts the delay; the pending sample is discarded.
- Validity: a sample is invalid if any field is 0.
- Match: a sample matches when all eight fields equal the reference snapshot.
  - On a mismatch, the reference is overwritten with the new sample.
- Totals: h_total and v_total are 15-bit zero-extended sums, computed from the sample; no overflow is possible.
- State machine (evaluated on the sample strobe):
  - IDLE: valid sample -> ACQ, cnt=1, store reference. Invalid sample -> stay in IDLE.
  - ACQ:
    - valid match -> cnt+1. When cnt reaches LOCK_FRAMES -> LOCKED.
    - valid mismatch -> cnt=1, new reference.
    - invalid -> IDLE, cnt=0.
  - LOCKED:
    - match -> stay.
    - valid mismatch -> ACQ, cnt=1, new reference, pulse o_fmt_change.
    - invalid -> IDLE, pulse o_fmt_change.
- Lock entry: o_locked rises and the o_h/v_* outputs load on the cycle after the strobe (1-cycle latency).
- Lock exit: o_locked falls on the cycle after the strobe. Latched outputs hold their last values until the next lock or reset.
- Watchdog:
  - Counter clears on pos_vs, otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES: o_no_signal=1, state -> IDLE, reference invalidated, cnt=0.
  - o_fmt_change pulses if the watchdog fires while in LOCKED.
  - o_no_signal clears on the cycle after the next pos_vs.
- Collisions: the watchdog cannot coincide with a strobe, because TIMEOUT_CYCLES > SAMPLE_DLY. A pos_vs in the same cycle as the strobe restarts the delay; the strobe still takes effect.
- Reset mid-operation: returns immediately to the reset state. Any pending sample is lost.

Optional Feature:
TIMING_TOL_EN:
- Defined: each field matches when |sample - reference| <= 1. On a tolerant match the reference is not updated, so drift cannot accumulate.
- Undefined: exact equality only.

Decomposition:
- Package timing_mon_pkg: FIELD_W=13, TOTAL_W=15, state localparams IDLE/ACQ/LOCKED, field index constants 0..7.
- Sub-module timing_field_cmp: one field and its reference in, match out; honours TIMING_TOL_EN. Instantiated 8 times.

Test Plan:
- 1080p fields (44,148,1920,88 / 5,36,1080,4), LOCK_FRAMES=3, six frames -> o_locked rises 1 cycle after 3rd strobe; o_h_total=2200, o_v_total=1125, o_h_active=1920, o_v_active=1080.
- Locked, then h_active changed to 1280 for one frame -> o_fmt_change 1-cycle pulse, o_locked=0, state ACQ; relock after 3 frames of 1280 gives o_h_total=1560.
- TIMEOUT_CYCLES=1000, VS stopped while locked -> at 1000 cycles o_no_signal=1, o_fmt_change pulse, state IDLE; VS restarts -> o_no_signal=0 after 1st pos_vs, lock after 3 frames.
- v_active=0 on frame 2 during ACQ -> state IDLE, cnt=0; lock requires 3 fresh identical frames.
- Second pos_vs 2 cycles after the first (SAMPLE_DLY=4) -> only one strobe, 4 cycles after the second edge; rst asserted mid-ACQ -> all outputs 0 next cycle.
- TIMING_TOL_EN defined, h_front_porch alternating 88/89 -> lock holds, no o_fmt_change; undefined -> never locks.
